// File: rtl/vec_pkg.sv
// Shared definitions for the slice selector / vector packer pair:
// default slice geometry, the packer state encoding and a clog2 helper.
`timescale 1ns/1ps
package vec_pkg;

    localparam int BIT_DEF = 32;
    localparam int NUM_DEF = 32;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Ceiling log2, evaluated at elaboration for counter widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/vec_pack_if.sv
// Slice-in / vector-out handshake bundle of the packer.
`timescale 1ns/1ps
interface vec_pack_if #(
    parameter int BIT   = 32,
    parameter int WIDTH = 1024
);
    logic             en;
    logic [BIT-1:0]   in;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;

    // Packer side
    modport slave (
        input  en, in, out_ready,
        output in_ready, out, out_valid
    );

    // Producer/consumer side
    modport master (
        output en, in, out_ready,
        input  in_ready, out, out_valid
    );
endinterface

// File: rtl/vec_pack.sv
// vec_pack: collects NUM serial slices of BIT bits into one WIDTH-bit
// vector. Slice k lands at out[k*BIT +: BIT]. One assembly register plus one
// output register let a new vector fill while the previous one waits.
`timescale 1ns/1ps
module vec_pack
    import vec_pkg::*;
#(
    parameter int BIT   = BIT_DEF,
    parameter int NUM   = NUM_DEF,
    parameter int WIDTH = BIT * NUM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    vec_pack_if.slave   bus
);

    localparam int            CW   = (clog2(NUM) < 1) ? 1 : clog2(NUM);
    localparam logic [CW-1:0] LAST = CW'(NUM - 1);

    if (WIDTH != BIT * NUM) begin : g_width_check
        $error("vec_pack: WIDTH must equal BIT*NUM");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             take;
    logic             slot_free;

    assign bus.in_ready  = (state_q == FILL);
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

    assign take      = out_valid_q && bus.out_ready;
    assign slot_free = !out_valid_q || bus.out_ready;

    // Next-state: slice assembly, output slot handoff and abort handling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        // Consumer handshake runs independently of clr; a new vector
        // loaded below overrides the drop.
        if (take) out_valid_d = 1'b0;

        if (clr) begin
            // Abort the partial (or pending) vector; output slot untouched.
            cnt_d   = '0;
            state_d = FILL;
            asm_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.en) begin
                        asm_d[int'(cnt_q) * BIT +: BIT] = bus.in;
                        if (cnt_q == LAST) begin
                            cnt_d = '0;
                            if (slot_free) begin
                                // Bypass: top slice goes straight to out.
                                out_d       = asm_d;
                                out_valid_d = 1'b1;
                            end else begin
                                state_d = HOLD;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Complete vector waits in asm until the slot empties.
                    if (bus.out_ready) begin
                        out_d       = asm_q;
                        out_valid_d = 1'b1;
                        state_d     = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            asm_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_vec_pack.sv
// Self-checking bench for vec_pack (BIT=32, NUM=32).
`timescale 1ns/1ps
module tb_vec_pack;

    localparam int BIT   = 32;
    localparam int NUM   = 32;
    localparam int WIDTH = BIT * NUM;

    typedef logic [WIDTH-1:0] vec_t;

    typedef struct {
        int          pre;     // slices sent before clr
        logic [31:0] base;    // fresh vector slice k = base + k
        logic [31:0] exp_s0;
        logic [31:0] exp_s31;
    } tv_t;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    int checks = 0;
    int errors = 0;

    vec_pack_if #(.BIT(BIT), .WIDTH(WIDTH)) bus ();

    vec_pack #(.BIT(BIT), .NUM(NUM), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sl(input vec_t v, input int k);
        return v[k*BIT +: BIT];
    endfunction

    function automatic vec_t ramp(input logic [31:0] base);
        vec_t v;
        for (int k = 0; k < NUM; k++) v[k*BIT +: BIT] = base + 32'(k);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < NUM; k++) begin
                if (sl(act, k) !== sl(exp, k)) begin
                    $display("FAIL %s: slice %0d got %h expected %h", name, k, sl(act, k), sl(exp, k));
                    break;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0;
        bus.en = 1'b0; bus.in = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one slice for one edge; back-to-back calls keep en high.
    task automatic send(input logic [31:0] v);
        bus.en = 1'b1;
        bus.in = v;
        @(posedge clk);
        #1 bus.en = 1'b0;
    endtask

    tv_t tv[4];

    initial begin
        tv[0] = '{pre: 10, base: 32'd100,        exp_s0: 32'd100,        exp_s31: 32'd131};
        tv[1] = '{pre: 0,  base: 32'd7,          exp_s0: 32'd7,          exp_s31: 32'd38};
        tv[2] = '{pre: 31, base: 32'd500,        exp_s0: 32'd500,        exp_s31: 32'd531};
        tv[3] = '{pre: 1,  base: 32'hFFFF_FFF0,  exp_s0: 32'hFFFF_FFF0,  exp_s31: 32'h0000_000F};

        // Reset state
        do_reset();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk_vec("rst_out", bus.out, '0);

        // Full throughput: two back-to-back vectors, out_ready high
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2 * NUM; k++) begin
            chk("thru_in_ready", bus.in_ready, 1);
            chk("thru_out_valid", bus.out_valid, (k == NUM) ? 1 : 0);
            if (k == NUM) chk_vec("thru_vec0", bus.out, ramp(0));
            send(32'(k));
        end
        chk("thru_last_valid", bus.out_valid, 1);
        chk_vec("thru_vec1", bus.out, ramp(32));
        @(posedge clk); #1;
        chk("thru_drop_valid", bus.out_valid, 0);
        chk_vec("thru_out_keep", bus.out, ramp(32));

        // Back-pressure: 64 slices with out_ready low, then one ready pulse
        do_reset();
        for (int k = 0; k < NUM; k++) send(32'(k));
        chk("bp_valid0", bus.out_valid, 1);
        for (int k = NUM; k < 2 * NUM; k++) begin
            chk("bp_in_ready_fill", bus.in_ready, 1);
            send(32'(k));
            chk_vec("bp_out_stable", bus.out, ramp(0));
        end
        chk("bp_hold_in_ready", bus.in_ready, 0);
        bus.en = 1'b1; bus.in = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 bus.en = 1'b0;
        chk("bp_hold_in_ready2", bus.in_ready, 0);
        chk("bp_hold_valid", bus.out_valid, 1);
        chk_vec("bp_hold_out", bus.out, ramp(0));
        bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        chk("bp_pulse_valid", bus.out_valid, 1);
        chk("bp_pulse_in_ready", bus.in_ready, 1);
        chk_vec("bp_pulse_out", bus.out, ramp(32));

        // Reach HOLD again, then reset inside HOLD
        for (int k = 0; k < NUM; k++) send(32'(64 + k));
        chk("hold2_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_hold_valid", bus.out_valid, 0);
        chk_vec("rst_hold_out", bus.out, '0);
        chk("rst_hold_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < NUM; k++) begin
            chk("rst_refill_no_valid", bus.out_valid, 0);
            send(32'(200 + k));
        end
        chk("rst_refill_valid", bus.out_valid, 1);
        chk_vec("rst_refill_vec", bus.out, ramp(200));

        // Table: clr after a partial vector, then a fresh vector
        foreach (tv[i]) begin
            do_reset();
            bus.out_ready = 1'b1;
            for (int k = 0; k < tv[i].pre; k++) send(32'(1000 + k));
            chk("clr_pre_valid", bus.out_valid, 0);
            clr = 1'b1; bus.en = 1'b1; bus.in = 32'h0000_270F;
            @(posedge clk); #1;
            clr = 1'b0; bus.en = 1'b0;
            for (int k = 0; k < NUM; k++) begin
                chk("clr_no_early_valid", bus.out_valid, 0);
                send(tv[i].base + 32'(k));
            end
            chk("clr_valid", bus.out_valid, 1);
            chk("clr_s0", sl(bus.out, 0), tv[i].exp_s0);
            chk("clr_s31", sl(bus.out, NUM - 1), tv[i].exp_s31);
            chk_vec("clr_vec", bus.out, ramp(tv[i].base));
        end

        // Random traffic against a queue-based reference model
        begin
            vec_t        pending[$];
            logic [31:0] part[$];
            vec_t        v;
            logic        acc, tk;
            do_reset();
            for (int cyc = 0; cyc < 1000; cyc++) begin
                bus.en        = ($urandom_range(0, 3) != 0);
                bus.in        = $urandom;
                bus.out_ready = ($urandom_range(0, 1) == 1);
                @(negedge clk);
                chk("rnd_in_ready", bus.in_ready, (pending.size() < 2) ? 1 : 0);
                chk("rnd_out_valid", bus.out_valid, (pending.size() > 0) ? 1 : 0);
                if (pending.size() > 0) chk_vec("rnd_out", bus.out, pending[0]);
                acc = bus.en && (pending.size() < 2);
                tk  = bus.out_ready && (pending.size() > 0);
                @(posedge clk); #1;
                if (tk) void'(pending.pop_front());
                if (acc) begin
                    part.push_back(bus.in);
                    if (part.size() == NUM) begin
                        for (int k = 0; k < NUM; k++) v[k*BIT +: BIT] = part[k];
                        pending.push_back(v);
                        part.delete();
                    end
                end
            end
            bus.en = 1'b0; bus.out_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
